// File: rtl/s_axi_rd.sv
// AXI4 read-channel slave: accepts one AR burst at a time, reads beats from a 1-cycle
// latency local memory port and returns them on R through a small credit-managed buffer.
module s_axi_rd #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int BUF_DEPTH          = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [C_S_AXI_ID_WIDTH-1:0]   s_axi_arid,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]                    s_axi_arlen,
    input  logic [2:0]                    s_axi_arsize,
    input  logic [1:0]                    s_axi_arburst,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [C_S_AXI_ID_WIDTH-1:0]   s_axi_rid,
    output logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rlast,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    output logic                          mem_rd_en,
    output logic [C_S_AXI_ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] mem_rd_data
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // Once rvalid is raised it stays high, with rdata/rresp/rlast/rid stable, until rready.

    localparam int ID_W   = C_S_AXI_ID_WIDTH;
    localparam int ADDR_W = C_S_AXI_ADDR_WIDTH;
    localparam int DATA_W = C_S_AXI_DATA_WIDTH;
    localparam int NSIZE  = $clog2(DATA_W / 8);
    localparam int PTR_W  = $clog2(BUF_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [ADDR_W-1:0] ALIGN_MASK  = {ADDR_W{1'b1}} << NSIZE;
    localparam logic [ADDR_W-1:0] BEAT_INC    = ADDR_W'(DATA_W / 8);
    localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(BUF_DEPTH);
    localparam logic [1:0]        RESP_OKAY   = 2'b00;
    localparam logic [1:0]        RESP_SLVERR = 2'b10;
    localparam logic [1:0]        BURST_INCR  = 2'b01;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                arready_q, arready_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          len_q, len_d;
    logic [1:0]          burst_q, burst_d;
    logic                err_q, err_d;
    logic [8:0]          iss_q, iss_d;
    logic [8:0]          ret_q, ret_d;
    logic                inflight_q, inflight_d;
    logic                inflight_last_q, inflight_last_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    buf_cnt_q, buf_cnt_d;
    logic                rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          rresp_q, rresp_d;
    logic                rlast_q, rlast_d;
    logic [ID_W-1:0]     rid_q, rid_d;

    logic [DATA_W-1:0]   buf_data_q [BUF_DEPTH];
    logic                buf_last_q [BUF_DEPTH];
    logic                buf_err_q  [BUF_DEPTH];

    logic                ar_hs;
    logic                r_hs;
    logic                issue;
    logic                buf_wr;
    logic                buf_rd;
    logic [DATA_W-1:0]   wr_data;

    always_comb begin
        state_d         = state_q;
        id_d            = id_q;
        addr_d          = addr_q;
        len_d           = len_q;
        burst_d         = burst_q;
        err_d           = err_q;
        iss_d           = iss_q;
        ret_d           = ret_q;
        rvalid_d        = rvalid_q;
        rdata_d         = rdata_q;
        rresp_d         = rresp_q;
        rlast_d         = rlast_q;
        rid_d           = rid_q;

        ar_hs  = (state_q == ST_IDLE) && arready_q && s_axi_arvalid;
        r_hs   = rvalid_q && s_axi_rready;
        // Credit rule: a read is only issued if its data is guaranteed a buffer slot.
        issue  = (state_q == ST_BURST) && (iss_q <= {1'b0, len_q}) &&
                 ((buf_cnt_q + CNT_W'(inflight_q)) < DEPTH_C);
        buf_wr = inflight_q;
        buf_rd = (buf_cnt_q != '0) && (!rvalid_q || s_axi_rready);

        wr_data         = err_q ? '0 : mem_rd_data;
        inflight_d      = issue;
        inflight_last_d = issue && (iss_q == {1'b0, len_q});

        case (state_q)
            ST_IDLE: begin
                if (ar_hs) begin
                    id_d    = s_axi_arid;
                    addr_d  = s_axi_araddr & ALIGN_MASK;
                    len_d   = s_axi_arlen;
                    burst_d = s_axi_arburst;
                    err_d   = (s_axi_arsize != 3'(NSIZE)) || s_axi_arburst[1];
                    iss_d   = '0;
                    ret_d   = '0;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (issue) begin
                    iss_d = iss_q + 9'd1;
                    if (burst_q == BURST_INCR) begin
                        addr_d = addr_q + BEAT_INC;
                    end
                end
                if (r_hs) begin
                    ret_d = ret_q + 9'd1;
                    if (ret_q == {1'b0, len_q}) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        arready_d = (state_d == ST_IDLE);

        wr_ptr_d  = buf_wr ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = buf_rd ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        buf_cnt_d = buf_cnt_q + CNT_W'(buf_wr) - CNT_W'(buf_rd);

        // The R register refills from the buffer head whenever it is empty or being drained.
        if (buf_rd) begin
            rvalid_d = 1'b1;
            rdata_d  = buf_data_q[rd_ptr_q];
            rresp_d  = buf_err_q[rd_ptr_q] ? RESP_SLVERR : RESP_OKAY;
            rlast_d  = buf_last_q[rd_ptr_q];
            rid_d    = id_q;
        end else if (r_hs) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            arready_q       <= 1'b0;
            id_q            <= '0;
            addr_q          <= '0;
            len_q           <= '0;
            burst_q         <= '0;
            err_q           <= 1'b0;
            iss_q           <= '0;
            ret_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            buf_cnt_q       <= '0;
            rvalid_q        <= 1'b0;
            rdata_q         <= '0;
            rresp_q         <= '0;
            rlast_q         <= 1'b0;
            rid_q           <= '0;
        end else begin
            state_q         <= state_d;
            arready_q       <= arready_d;
            id_q            <= id_d;
            addr_q          <= addr_d;
            len_q           <= len_d;
            burst_q         <= burst_d;
            err_q           <= err_d;
            iss_q           <= iss_d;
            ret_q           <= ret_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            buf_cnt_q       <= buf_cnt_d;
            rvalid_q        <= rvalid_d;
            rdata_q         <= rdata_d;
            rresp_q         <= rresp_d;
            rlast_q         <= rlast_d;
            rid_q           <= rid_d;
        end
    end

    // Buffer storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (buf_wr) begin
            buf_data_q[wr_ptr_q] <= wr_data;
            buf_last_q[wr_ptr_q] <= inflight_last_q;
            buf_err_q[wr_ptr_q]  <= err_q;
        end
    end

    assign s_axi_arready = arready_q;
    assign s_axi_rid     = rid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rvalid  = rvalid_q;
    assign mem_rd_en     = issue;
    assign mem_rd_addr   = addr_q;

endmodule

// File: tb/tb_s_axi_rd.sv
// Bench for s_axi_rd: directed and random bursts against a beat-list reference model,
// with a behavioural 1-cycle-latency memory behind the local read port.
module tb_s_axi_rd;

    localparam int ID_W      = 1;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int BUF_DEPTH = 4;
    localparam int BEAT_W    = ID_W + 2 + 1 + DATA_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ID_W-1:0]   s_axi_arid = '0;
    logic [ADDR_W-1:0] s_axi_araddr = '0;
    logic [7:0]        s_axi_arlen = '0;
    logic [2:0]        s_axi_arsize = '0;
    logic [1:0]        s_axi_arburst = '0;
    logic              s_axi_arvalid = 1'b0;
    logic              s_axi_arready;
    logic [ID_W-1:0]   s_axi_rid;
    logic [DATA_W-1:0] s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rlast;
    logic              s_axi_rvalid;
    logic              s_axi_rready = 1'b0;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data = '0;

    int n_assert = 0;
    int n_fail   = 0;
    logic [BEAT_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];

    s_axi_rd #(
        .C_S_AXI_ID_WIDTH  (ID_W),
        .C_S_AXI_ADDR_WIDTH(ADDR_W),
        .C_S_AXI_DATA_WIDTH(DATA_W),
        .BUF_DEPTH         (BUF_DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_axi_arid   (s_axi_arid),
        .s_axi_araddr (s_axi_araddr),
        .s_axi_arlen  (s_axi_arlen),
        .s_axi_arsize (s_axi_arsize),
        .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rid    (s_axi_rid),
        .s_axi_rdata  (s_axi_rdata),
        .s_axi_rresp  (s_axi_rresp),
        .s_axi_rlast  (s_axi_rlast),
        .s_axi_rvalid (s_axi_rvalid),
        .s_axi_rready (s_axi_rready),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] mem_fn(input logic [ADDR_W-1:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
    endfunction

    // Memory contents are a fixed function of address; data is only meaningful the
    // cycle after a strobe, otherwise a poison value is driven.
    always @(posedge clk) begin
        mem_rd_data <= mem_rd_en ? mem_fn(mem_rd_addr) : 32'hDEAD_BEEF;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_arready"}, s_axi_arready, 0);
        chk({tag, "_rvalid"},  s_axi_rvalid, 0);
        chk({tag, "_rlast"},   s_axi_rlast, 0);
        chk({tag, "_rdata"},   s_axi_rdata, 0);
        chk({tag, "_rresp"},   s_axi_rresp, 0);
        chk({tag, "_rid"},     s_axi_rid, 0);
        chk({tag, "_mem_en"},  mem_rd_en, 0);
    endtask

    // Runs one burst. rr_pct is the per-cycle rready probability; abort_at >= 0 asserts
    // reset while beat number abort_at (0-based) is being presented.
    task automatic run_burst(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                             input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input int rr_pct, input int abort_at);
        logic              err;
        logic [ADDR_W-1:0] a;
        logic [BEAT_W-1:0] beat, prev_beat, exp_beat;
        logic              prev_stall;
        int n, issued, returned, first_v, first_hs, last_hs, waited;

        err = (size != 3'd2) || burst[1];
        exp_q.delete();
        exp_addr_q.delete();
        for (int i = 0; i <= int'(len); i++) begin
            a = (burst == 2'b00) ? (addr & ~32'h3) : ((addr & ~32'h3) + 32'(i) * 32'd4);
            exp_addr_q.push_back(a);
            exp_q.push_back({id, (err ? 2'b10 : 2'b00), (i == int'(len)), (err ? 32'h0 : mem_fn(a))});
        end

        @(negedge clk);
        s_axi_arid    = id;
        s_axi_araddr  = addr;
        s_axi_arlen   = len;
        s_axi_arsize  = size;
        s_axi_arburst = burst;
        s_axi_arvalid = 1'b1;
        waited = 0;
        while (s_axi_arready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("ar_accept", s_axi_arready, 1);
        if (s_axi_arready !== 1'b1) begin
            s_axi_arvalid = 1'b0;
            return;
        end
        @(posedge clk);

        n = 0; issued = 0; returned = 0; first_v = -1; first_hs = -1; last_hs = -1;
        prev_stall = 1'b0;
        prev_beat = '0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                s_axi_arvalid = 1'b0;
                chk("arready_low_in_burst", s_axi_arready, 0);
            end
            beat = {s_axi_rid, s_axi_rresp, s_axi_rlast, s_axi_rdata};
            if (mem_rd_en === 1'b1) begin
                if (!err && issued < exp_addr_q.size())
                    chk($sformatf("mem_addr%0d", issued), mem_rd_addr, exp_addr_q[issued]);
                issued++;
                chk("outstanding_bound", ((issued - returned) <= BUF_DEPTH + 1), 1);
            end
            if (prev_stall) chk("stall_hold", {s_axi_rvalid, beat}, {1'b1, prev_beat});
            if (s_axi_rvalid === 1'b1 && first_v < 0) first_v = n;
            if (abort_at >= 0 && s_axi_rvalid === 1'b1 && returned == abort_at) begin
                rst_n = 1'b0;
                s_axi_rready = 1'b0;
                @(posedge clk);
                @(negedge clk);
                chk_reset_outputs("abort");
                rst_n = 1'b1;
                @(negedge clk);
                chk("abort_no_rvalid", s_axi_rvalid, 0);
                chk("abort_arready_up", s_axi_arready, 1);
                exp_q.delete();
                return;
            end
            s_axi_rready = ($urandom_range(99) < rr_pct);
            if (s_axi_rvalid === 1'b1 && s_axi_rready) begin
                exp_beat = exp_q.pop_front();
                chk($sformatf("beat%0d", returned), beat, exp_beat);
                if (first_hs < 0) first_hs = n;
                last_hs = n;
                returned++;
            end
            prev_stall = (s_axi_rvalid === 1'b1) && !s_axi_rready;
            prev_beat = beat;
        end

        chk("burst_complete", exp_q.size(), 0);
        chk("issue_count", issued, int'(len) + 1);
        chk("first_rvalid_latency", first_v - 1, 3);
        if (rr_pct >= 100) chk("throughput", last_hs - first_hs, int'(len));
        @(negedge clk);
        s_axi_rready = 1'b0;
        chk("rvalid_after_burst", s_axi_rvalid, 0);
        chk("arready_after_burst", s_axi_arready, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("arready_after_reset", s_axi_arready, 1);

        run_burst(1'b1, 32'h40,  8'd0,  3'd2, 2'b01, 100, -1);
        run_burst(1'b0, 32'h100, 8'd15, 3'd2, 2'b01, 100, -1);
        run_burst(1'b1, 32'h100, 8'd15, 3'd2, 2'b01, 50,  -1);
        run_burst(1'b0, 32'h20,  8'd3,  3'd2, 2'b00, 100, -1);
        run_burst(1'b1, 32'h80,  8'd3,  3'd2, 2'b10, 70,  -1);
        run_burst(1'b0, 32'h84,  8'd3,  3'd0, 2'b01, 100, -1);
        run_burst(1'b1, 32'h90,  8'd2,  3'd2, 2'b11, 100, -1);
        run_burst(1'b1, 32'h200, 8'd15, 3'd2, 2'b01, 100, 4);
        run_burst(1'b0, 32'h300, 8'd0,  3'd2, 2'b01, 100, -1);
        run_burst(1'b1, 32'h104, 8'd20, 3'd2, 2'b01, 20,  -1);

        for (int k = 0; k < 8; k++) begin
            logic [1:0] b;
            logic [2:0] s;
            b = ($urandom_range(9) < 7) ? 2'($urandom_range(1)) : 2'($urandom_range(3));
            s = ($urandom_range(9) < 8) ? 3'd2 : 3'($urandom_range(7));
            run_burst(1'($urandom_range(1)), $urandom, 8'($urandom_range(24)), s, b,
                      30 + int'($urandom_range(70)), -1);
        end

        run_burst(1'b1, 32'hFFFF_FF00, 8'd255, 3'd2, 2'b01, 100, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
